// File: rtl/han_carlson_pipe_adder_pkg.sv
// ppa_pkg: shared types and elaboration helpers for the pipelined
// Han-Carlson adder.
//   gp_t       : generate/propagate pair for one bit or group.
//   op_e       : add / subtract operation select.
//   levels     : number of prefix levels for a width, log2(width)+1.
//   rank_level : prefix level after which register rank r sits.
//   is_cut     : 1 if some intermediate rank sits after prefix level n.
package ppa_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned levels(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  function automatic int unsigned rank_level(input int unsigned r,
                                             input int unsigned stages,
                                             input int unsigned lv);
    return (r * lv) / stages;
  endfunction

  function automatic bit is_cut(input int unsigned n,
                                input int unsigned stages,
                                input int unsigned lv);
    for (int unsigned r = 1; r < stages; r++) begin
      if (rank_level(r, stages, lv) == n) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/han_carlson_pipe_adder_prefix.sv
// hc_prefix_level: one combinational Han-Carlson prefix level.
//   LEVEL < log2(WIDTH): Kogge-Stone step on odd bits, distance 2**LEVEL.
//   LEVEL = log2(WIDTH): final fill of even bits from their odd neighbour.
// Ports:
//   gp_i : group G/P vector entering the level.
//   gp_o : group G/P vector leaving the level.
module hc_prefix_level
  import ppa_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEVEL = 0
) (
  input  gp_t [WIDTH-1:0] gp_i,
  output gp_t [WIDTH-1:0] gp_o
);

  localparam int unsigned LOG2W = $clog2(WIDTH);
  localparam int unsigned DIST  = (LEVEL < LOG2W) ? (32'd1 << LEVEL) : 32'd1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam bit ODD    = (i % 2) == 1;
    localparam bit ACTIVE = (LEVEL < LOG2W) ? (ODD && (i >= DIST))
                                            : (!ODD && (i > 0));
    if (ACTIVE) begin : g_cell
      assign gp_o[i].g = gp_i[i].g | (gp_i[i].p & gp_i[i-DIST].g);
      assign gp_o[i].p = gp_i[i].p & gp_i[i-DIST].p;
    end else begin : g_pass
      assign gp_o[i] = gp_i[i];
    end
  end

endmodule

// File: rtl/han_carlson_pipe_adder.sv
// han_carlson_pipe_adder: parametrised, pipelined Han-Carlson add/subtract
// with a global-stall valid/ready handshake.
// Optional macro PPA_FLAGS_EN adds out_ovf / out_zero result flags.
// Ports:
//   clk, rst              : clock, synchronous active-high reset.
//   in_valid/in_ready     : operand beat handshake.
//   in_a, in_b            : operands (WIDTH bits).
//   in_cin                : carry-in, add mode only.
//   in_sub                : 1 selects A + ~B + 1 (in_cin ignored).
//   out_valid/out_ready   : result handshake.
//   out_sum, out_cout     : result and carry out of the MSB.
//   out_ovf, out_zero     : signed overflow / zero result (PPA_FLAGS_EN).
module han_carlson_pipe_adder
  import ppa_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PPA_FLAGS_EN
  ,
  output logic             out_ovf,
  output logic             out_zero
`endif
);

  localparam int unsigned LEVELS = levels(WIDTH);

  logic             en;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH-1:0] p_pre;
  gp_t  [WIDTH-1:0] gp_pre;

  // Carry-in is folded into bit 0's generate so the prefix tree's group G
  // is directly the carry C[i]; the unmodified P vector travels alongside.
  always_comb begin
    op    = in_sub ? OP_SUB : OP_ADD;
    b_eff = (op == OP_SUB) ? ~in_b : in_b;
    c0    = (op == OP_SUB) ? 1'b1 : in_cin;
    p_pre = in_a ^ b_eff;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      gp_pre[i].g = in_a[i] & b_eff[i];
      gp_pre[i].p = p_pre[i];
    end
    gp_pre[0].g = (in_a[0] & b_eff[0]) | (p_pre[0] & c0);
  end

  // One block per prefix level; a register rank is placed in front of
  // level n whenever some rank sits after n levels, otherwise it is wired.
  for (genvar n = 0; n < LEVELS; n++) begin : g_stage
    gp_t  [WIDTH-1:0] gp_in;
    gp_t  [WIDTH-1:0] gp_out;
    logic [WIDTH-1:0] p_in;
    logic             c0_in;
    logic             v_in;

    if (n == 0) begin : g_head
      assign gp_in = gp_pre;
      assign p_in  = p_pre;
      assign c0_in = c0;
      assign v_in  = in_valid;
    end else if (is_cut(n, PIPE_STAGES, LEVELS)) begin : g_reg
      gp_t  [WIDTH-1:0] gp_q;
      logic [WIDTH-1:0] p_q;
      logic             c0_q;
      logic             v_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          gp_q <= '0;
          p_q  <= '0;
          c0_q <= 1'b0;
          v_q  <= 1'b0;
        end else if (en) begin
          gp_q <= g_stage[n-1].gp_out;
          p_q  <= g_stage[n-1].p_in;
          c0_q <= g_stage[n-1].c0_in;
          v_q  <= g_stage[n-1].v_in;
        end
      end

      assign gp_in = gp_q;
      assign p_in  = p_q;
      assign c0_in = c0_q;
      assign v_in  = v_q;
    end else begin : g_wire
      assign gp_in = g_stage[n-1].gp_out;
      assign p_in  = g_stage[n-1].p_in;
      assign c0_in = g_stage[n-1].c0_in;
      assign v_in  = g_stage[n-1].v_in;
    end

    hc_prefix_level #(
      .WIDTH(WIDTH),
      .LEVEL(n)
    ) u_level (
      .gp_i(gp_in),
      .gp_o(gp_out)
    );
  end

  logic [WIDTH-1:0] carry;

  always_comb begin
    carry = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry[i] = g_stage[LEVELS-1].gp_out[i].g;
    end
    sum_d  = g_stage[LEVELS-1].p_in ^ {carry[WIDTH-2:0], g_stage[LEVELS-1].c0_in};
    cout_d = carry[WIDTH-1];
  end

`ifdef PPA_FLAGS_EN
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;

  always_comb begin
    ovf_d  = carry[WIDTH-1] ^ carry[WIDTH-2];
    zero_d = (sum_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_ovf  = ovf_q;
  assign out_zero = zero_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else if (en) begin
      out_valid_q <= g_stage[LEVELS-1].v_in;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_han_carlson_pipe_adder.sv
// Testbench for han_carlson_pipe_adder, WIDTH=32, PIPE_STAGES=3.
// Directed vector table plus hand-written backpressure and mid-flight reset
// sequences. Flag checks are compiled when PPA_FLAGS_EN is defined.
module tb_han_carlson_pipe_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_sum;
  logic        out_cout;
`ifdef PPA_FLAGS_EN
  logic        out_ovf;
  logic        out_zero;
`endif

  han_carlson_pipe_adder #(
    .WIDTH(32),
    .PIPE_STAGES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_cin(in_cin),
    .in_sub(in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_cout(out_cout)
`ifdef PPA_FLAGS_EN
    ,
    .out_ovf(out_ovf),
    .out_zero(out_zero)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int got;
    int cyc;
    int waited;
    bit have_hold;
    logic [31:0] hold_sum;

    //            a             b             cin   sub   sum           cout  ovf   zero
    vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0, 32'hDEADBEF0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};

    // Reset held two cycles with in_valid asserted.
    rst = 1'b1; in_valid = 1'b1; in_a = 32'h1234; in_b = 32'h1;
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_cout", 64'(out_cout), 64'd0);
`ifdef PPA_FLAGS_EN
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    step();
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, one isolated beat each, exact latency checked.
    out_ready = 1'b1;
    for (int unsigned k = 0; k < 12; k++) begin
      in_a = vecs[k].a; in_b = vecs[k].b; in_cin = vecs[k].cin; in_sub = vecs[k].sub;
      in_valid = 1'b1;
      #1;
      check("vec_in_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check("vec_lat_t0", 64'(out_valid), 64'd0);
      step();
      check("vec_lat_t1", 64'(out_valid), 64'd0);
      step();
      check("vec_valid", 64'(out_valid), 64'd1);
      check("vec_sum", 64'(out_sum), 64'(vecs[k].sum));
      check("vec_cout", 64'(out_cout), 64'(vecs[k].cout));
`ifdef PPA_FLAGS_EN
      check("vec_ovf", 64'(out_ovf), 64'(vecs[k].ovf));
      check("vec_zero", 64'(out_zero), 64'(vecs[k].zero));
`endif
      step();
      check("vec_drain", 64'(out_valid), 64'd0);
    end

    // Backpressure: 6 beats A=B=i, out_ready low for cycles 4..6.
    sent = 0; got = 0; cyc = 0; have_hold = 1'b0; hold_sum = '0;
    while (got < 6 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (sent < 6);
      in_a = 32'(sent); in_b = 32'(sent); in_cin = 1'b0; in_sub = 1'b0;
      #1;
      if (!out_ready && out_valid) begin
        check("bp_in_ready", 64'(in_ready), 64'd0);
        if (have_hold) check("bp_hold_sum", 64'(out_sum), 64'(hold_sum));
        else begin
          hold_sum  = out_sum;
          have_hold = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        check("bp_order", 64'(out_sum), 64'(2 * got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp_count", 64'(got), 64'd6);
    check("bp_stall_seen", 64'(have_hold), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      step();
      check("bp_no_dup", 64'(out_valid), 64'd0);
    end

    // Reset mid-flight: two beats accepted, reset before either emerges.
    in_sub = 1'b0; in_cin = 1'b0;
    in_a = 32'd100; in_b = 32'd1; in_valid = 1'b1;
    step();
    in_a = 32'd200; in_b = 32'd2;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      check("mid_rst_quiet", 64'(out_valid), 64'd0);
      step();
    end
    in_a = 32'h1111; in_b = 32'h2222; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 10) begin
      step();
      waited++;
    end
    check("mid_rst_found", 64'(out_valid), 64'd1);
    check("mid_rst_latency", 64'(waited), 64'd2);
    check("mid_rst_sum", 64'(out_sum), 64'h3333);
    step();
    check("mid_rst_single", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
